// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit command driver: state encoding,
// command word layout and the reference mux rule used for checking.
package lu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_HOLD  = ST_HOLD
    } lu_state_t;

    localparam int CMD_W    = 4;
    localparam int CMD_A    = 3;
    localparam int CMD_B    = 2;
    localparam int CMD_SEL1 = 1;
    localparam int CMD_SEL2 = 0;

    // Value a healthy 2:1 mux must produce for the given select/operands.
    function automatic logic mux_expect(input logic sel, input logic a, input logic b);
        return sel ? b : a;
    endfunction

endpackage

// File: rtl/lu_cmd_fifo.sv
// Small command FIFO with occupancy count; overflow/underflow requests are ignored.
module lu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [CMD_W-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [CMD_W-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mux.sv
// Dual 2:1 logic-unit cell driven by lu_cmd_driver.
module mux (
    output logic s1,
    output logic s2,
    input  logic a,
    input  logic b,
    input  logic sel1,
    input  logic sel2
);

    assign s1 = sel1 ? b : a;
    assign s2 = sel2 ? b : a;

endmodule

// File: rtl/lu_cmd_driver.sv
// Buffers operand/select commands, drives them one at a time into the dual
// 2:1 mux cell, waits a settle interval, captures and checks the outputs and
// hands the result downstream over a valid/ready handshake.
module lu_cmd_driver
    import lu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_a,
    input  logic                   cmd_b,
    input  logic                   cmd_sel1,
    input  logic                   cmd_sel2,
    output logic                   lu_a,
    output logic                   lu_b,
    output logic                   lu_sel1,
    output logic                   lu_sel2,
    input  logic                   lu_s1,
    input  logic                   lu_s2,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_s1,
    output logic                   res_s2,
    output logic                   res_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

    lu_state_t             r_state;
    lu_state_t             w_state_nxt;
    logic [SET_W-1:0]      r_settle;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CMD_W-1:0]      w_head;
    logic [CMD_W-1:0]      w_cmd;
    logic [$clog2(DEPTH):0] w_count;
    logic                  r_lu_a;
    logic                  r_lu_b;
    logic                  r_lu_sel1;
    logic                  r_lu_sel2;
    logic                  r_e1;
    logic                  r_e2;
    logic                  r_res_valid;
    logic                  r_res_s1;
    logic                  r_res_s2;
    logic                  r_res_err;

    assign w_cmd     = {cmd_a, cmd_b, cmd_sel1, cmd_sel2};
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;

    lu_cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_cmd),
        .i_pop   (w_load),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state plus load (pop) and capture strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_settle == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Settle counter: loaded with SETTLE-1 on each load, counts down in DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
        end else if (w_load) begin
            r_settle <= SETTLE_LOAD;
        end else if (r_state == S_DRIVE && r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
        end
    end

    // LU drive registers: change only when a command is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_a    <= 1'b0;
            r_lu_b    <= 1'b0;
            r_lu_sel1 <= 1'b0;
            r_lu_sel2 <= 1'b0;
        end else if (w_load) begin
            r_lu_a    <= w_head[CMD_A];
            r_lu_b    <= w_head[CMD_B];
            r_lu_sel1 <= w_head[CMD_SEL1];
            r_lu_sel2 <= w_head[CMD_SEL2];
        end
    end

    // Expected mux outputs latched alongside the loaded command.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_e1 <= mux_expect(w_head[CMD_SEL1], w_head[CMD_A], w_head[CMD_B]);
            r_e2 <= mux_expect(w_head[CMD_SEL2], w_head[CMD_A], w_head[CMD_B]);
        end
    end

    // Result registers: captured at the end of the settle interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_s1  <= 1'b0;
            r_res_s2  <= 1'b0;
            r_res_err <= 1'b0;
        end else if (w_capture) begin
            r_res_s1  <= lu_s1;
            r_res_s2  <= lu_s2;
            r_res_err <= (lu_s1 != r_e1) | (lu_s2 != r_e2);
        end
    end

    // Result valid: set on capture, cleared by the downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign lu_a      = r_lu_a;
    assign lu_b      = r_lu_b;
    assign lu_sel1   = r_lu_sel1;
    assign lu_sel2   = r_lu_sel2;
    assign res_valid = r_res_valid;
    assign res_s1    = r_res_s1;
    assign res_s2    = r_res_s2;
    assign res_err   = r_res_err;
    assign count     = w_count;
    assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_lu_cmd_driver.sv
// Scoreboard bench for lu_cmd_driver driving the real mux cell (SETTLE=1),
// plus a second instance built with SETTLE=3 for timing and reset checks.
module tb_lu_cmd_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 1 (SETTLE=1)
    logic       cmd_valid, cmd_ready, cmd_a, cmd_b, cmd_sel1, cmd_sel2;
    logic       lu_a, lu_b, lu_sel1, lu_sel2, lu_s1, lu_s2, m_s1, m_s2;
    logic       res_valid, res_ready, res_s1, res_s2, res_err, busy;
    logic [2:0] count;
    logic       stuck;

    // Instance 3 (SETTLE=3)
    logic       c3_valid, c3_ready, c3_a, c3_b, c3_sel1, c3_sel2;
    logic       l3_a, l3_b, l3_sel1, l3_sel2, l3_s1, l3_s2;
    logic       r3_valid, r3_ready, r3_s1, r3_s2, r3_err, busy3;
    logic [2:0] count3;

    mux u_mux1 (.s1(m_s1), .s2(m_s2), .a(lu_a), .b(lu_b), .sel1(lu_sel1), .sel2(lu_sel2));
    assign lu_s1 = stuck ? 1'b1 : m_s1;
    assign lu_s2 = m_s2;

    mux u_mux3 (.s1(l3_s1), .s2(l3_s2), .a(l3_a), .b(l3_b), .sel1(l3_sel1), .sel2(l3_sel2));

    lu_cmd_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel1(cmd_sel1), .cmd_sel2(cmd_sel2),
        .lu_a(lu_a), .lu_b(lu_b), .lu_sel1(lu_sel1), .lu_sel2(lu_sel2),
        .lu_s1(lu_s1), .lu_s2(lu_s2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s1(res_s1), .res_s2(res_s2), .res_err(res_err),
        .busy(busy), .count(count)
    );

    lu_cmd_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_a(c3_a), .cmd_b(c3_b), .cmd_sel1(c3_sel1), .cmd_sel2(c3_sel2),
        .lu_a(l3_a), .lu_b(l3_b), .lu_sel1(l3_sel1), .lu_sel2(l3_sel2),
        .lu_s1(l3_s1), .lu_s2(l3_s2),
        .res_valid(r3_valid), .res_ready(r3_ready),
        .res_s1(r3_s1), .res_s2(r3_s2), .res_err(r3_err),
        .busy(busy3), .count(count3)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    int         hs_q[$];
    logic       rec_hs   = 1'b0;
    logic       rand_mode = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: ideal mux rule, optional stuck-at-1 on s1.
    function automatic logic [2:0] model(input logic [3:0] c, input logic stuck_s1);
        logic a, b, s1sel, s2sel, ideal1, ideal2, obs1;
        a = c[3]; b = c[2]; s1sel = c[1]; s2sel = c[0];
        ideal1 = s1sel ? b : a;
        ideal2 = s2sel ? b : a;
        obs1   = stuck_s1 ? 1'b1 : ideal1;
        return {obs1, ideal2, (obs1 != ideal1)};
    endfunction

    // Offer one command to instance 1; expected result queued on acceptance.
    task automatic push_cmd(input logic [3:0] c);
        int w = 0;
        {cmd_a, cmd_b, cmd_sel1, cmd_sel2} = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
            if (rand_mode) res_ready = ($urandom_range(0, 3) != 0);
        end
        if (!cmd_ready) begin
            check("push_timeout", {7'd0, cmd_ready}, 8'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(c, stuck));
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push3(input logic [3:0] c);
        int w = 0;
        {c3_a, c3_b, c3_sel1, c3_sel2} = c;
        c3_valid = 1'b1;
        while (!c3_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("push3_ready", {7'd0, c3_ready}, 8'd1);
        @(posedge clk); #1;
        c3_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_busy", {7'd0, busy}, 8'd0);
        check("drain_left", 8'(exp_q.size()), 8'd0);
    endtask

    // Monitor: compares every accepted result against the scoreboard.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {7'd0, res_valid}, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_s1", {7'd0, res_s1}, {7'd0, e[2]});
                    check("res_s2", {7'd0, res_s2}, {7'd0, e[1]});
                    check("res_err", {7'd0, res_err}, {7'd0, e[0]});
                    if (rec_hs) hs_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        logic [3:0] c;
        logic       stale;
        rst = 1'b1;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel1 = 0; cmd_sel2 = 0;
        c3_valid = 0; c3_a = 0; c3_b = 0; c3_sel1 = 0; c3_sel2 = 0;
        res_ready = 0; r3_ready = 0; stuck = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("rst_count", {5'd0, count}, 8'd0);
        check("rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("rst_lu", {4'd0, lu_a, lu_b, lu_sel1, lu_sel2}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single command, observe latency, then release.
        res_ready = 1'b0;
        push_cmd(4'b1010);
        @(posedge clk); #1;
        check("single_lu", {4'd0, lu_a, lu_b, lu_sel1, lu_sel2}, 8'b1010);
        check("single_early_valid", {7'd0, res_valid}, 8'd0);
        @(posedge clk); #1;
        check("single_valid", {7'd0, res_valid}, 8'd1);
        check("single_s1", {7'd0, res_s1}, 8'd0);
        check("single_s2", {7'd0, res_s2}, 8'd1);
        check("single_err", {7'd0, res_err}, 8'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("single_release_valid", {7'd0, res_valid}, 8'd0);
        check("single_release_busy", {7'd0, busy}, 8'd0);

        // Exhaustive sweep back-to-back: results every 2 cycles.
        hs_q.delete();
        rec_hs = 1'b1;
        for (int i = 0; i < 16; i++) push_cmd(4'(i));
        wait_drain();
        rec_hs = 1'b0;
        check("sweep_count", 8'(hs_q.size()), 8'd16);
        for (int k = 1; k < hs_q.size(); k++)
            check("sweep_gap", 8'(hs_q[k] - hs_q[k-1]), 8'd2);

        // Fill and backpressure.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(4'($urandom_range(0, 15)));
        check("fill_count", {5'd0, count}, 8'd4);
        check("fill_ready", {7'd0, cmd_ready}, 8'd0);
        {cmd_a, cmd_b, cmd_sel1, cmd_sel2} = 4'b1111;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_ready", {7'd0, cmd_ready}, 8'd0);
        check("hold_count", {5'd0, count}, 8'd4);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain();
        check("drain_count", {5'd0, count}, 8'd0);
        check("drain_ready", {7'd0, cmd_ready}, 8'd1);

        // Stuck-at-1 on s1 must be flagged.
        stuck = 1'b1;
        push_cmd(4'b0000);
        wait_drain();
        stuck = 1'b0;

        // Randomized traffic with random downstream readiness.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            push_cmd(4'($urandom_range(0, 15)));
        end
        rand_mode = 1'b0;
        res_ready = 1'b1;
        wait_drain();

        // SETTLE=3 instance: lu_* held 3 cycles, valid 4 edges after acceptance.
        push3(4'b0110);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            check("s3_lu_stable", {4'd0, l3_a, l3_b, l3_sel1, l3_sel2}, 8'b0110);
            check("s3_not_yet", {7'd0, r3_valid}, 8'd0);
        end
        @(posedge clk); #1;
        check("s3_valid", {7'd0, r3_valid}, 8'd1);
        check("s3_s1", {7'd0, r3_s1}, 8'd1);
        check("s3_s2", {7'd0, r3_s2}, 8'd0);
        check("s3_err", {7'd0, r3_err}, 8'd0);
        r3_ready = 1'b1;
        @(posedge clk); #1;
        check("s3_release", {7'd0, r3_valid}, 8'd0);
        r3_ready = 1'b0;

        // Asynchronous reset while the SETTLE=3 instance is in DRIVE with 2 queued.
        c = 4'b1001;
        push3(c);
        push3(~c);
        push3(c);
        check("mid_pre_count", {5'd0, count3}, 8'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", {7'd0, r3_valid}, 8'd0);
        check("mid_count", {5'd0, count3}, 8'd0);
        check("mid_lu", {4'd0, l3_a, l3_b, l3_sel1, l3_sel2}, 8'd0);
        check("mid_ready", {7'd0, c3_ready}, 8'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        r3_ready = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            stale = stale | r3_valid;
        end
        check("mid_no_stale", {7'd0, stale}, 8'd0);
        check("mid_idle", {7'd0, busy3}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lu_cmd_driver.md
Name: lu_cmd_driver

Overview:
- Upstream command stage for the dual 2:1 logic-unit cell `mux`. That cell has ports (s1, s2, a, b, sel1, sel2), with s1 = sel1 ? b : a and s2 = sel2 ? b : a.
- Accepts operand/select commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives one command at a time into the LU and waits a settle interval.
- Captures s1/s2, checks them against the expected values, and presents the result over a valid/ready handshake to downstream logic.

Parameters:
- DEPTH, 4, command FIFO depth; power of 2, at least 2.
- SETTLE, 1, number of cycles lu_* are held stable before lu_s1/lu_s2 are sampled; at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_a  input  1  operand a.
- cmd_b  input  1  operand b.
- cmd_sel1  input  1  select for s1.
- cmd_sel2  input  1  select for s2.
- lu_a  output  1  drives LU input a.
- lu_b  output  1  drives LU input b.
- lu_sel1  output  1  drives LU input sel1.
- lu_sel2  output  1  drives LU input sel2.
- lu_s1  input  1  LU output s1.
- lu_s2  input  1  LU output s2.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_s1  output  1  captured s1.
- res_s2  output  1  captured s2.
- res_err  output  1  captured value differs from expected mux result.
- busy  output  1  state != IDLE or FIFO non-empty.
- count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count go to 0; state goes to IDLE; SETTLE counter goes to 0.
  - lu_a, lu_b, lu_sel1, lu_sel2, res_valid, res_s1, res_s2 and res_err go to 0.
  - Any in-flight command or result is discarded.
  - cmd_ready is 1 after reset.
- Push:
  - Occurs on a clk edge with cmd_valid & cmd_ready. The entry is {a,b,sel1,sel2}.
  - When full, cmd_ready=0, even if a pop happens in the same cycle; no push is accepted.
- Pop:
  - Occurs only from the FSM (IDLE, or HOLD on a handshake) when FIFO count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count > 0, pop the head, load lu_* from it, latch expected e1 = sel1 ? b : a and e2 = sel2 ? b : a, load counter = SETTLE-1, and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: if counter != 0, decrement. If counter == 0, register res_s1 = lu_s1, res_s2 = lu_s2, res_err = (lu_s1 != e1) | (lu_s2 != e2), set res_valid=1, and go to HOLD.
  - HOLD: res_valid=1 and results stay stable until res_ready. On res_valid & res_ready:
    - if count > 0, pop and load the next command exactly as from IDLE, and go to DRIVE (back-to-back);
    - otherwise go to IDLE.
    - res_valid deasserts unless re-asserted by a later capture.
- lu_* hold their last loaded values outside DRIVE; they change only on a load.
- Latency: a command pushed at edge E0 into an empty, idle block is loaded at E1 and gives res_valid=1 after edge E1+SETTLE. With SETTLE=1, that is 2 edges after acceptance.
- Throughput: one result per SETTLE+1 cycles with res_ready held high.
- A command presented while the block is IDLE with an empty FIFO still passes through the FIFO; there is no bypass.
- res_err is informational only; it does not stall or reorder.
- Widths are 1-bit data throughout; count width is $clog2(DEPTH)+1, so DEPTH itself is representable.

Decomposition:
- Shared package lu_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_HOLD=2'd2;
  - CMD_W=4 and the field bit positions (A=3, B=2, SEL1=1, SEL2=0).
- One sub-module: lu_cmd_fifo (DEPTH, CMD_W). It provides push/pop, full/empty, count and async reset.
- FSM, expected-value logic and result registers live in lu_cmd_driver.
- The bench instantiates lu_cmd_driver connected to the real mux cell.

Test Plan:
- Reset, single command, then release: cmd {a=1,b=0,sel1=1,sel2=0} at E0 -> lu_*=1,0,1,0 after E1; after E2 res_valid=1, res_s1=0, res_s2=1, res_err=0; res_ready=1 -> res_valid=0 next edge, busy=0.
- Exhaustive sweep: all 16 {a,b,sel1,sel2} combinations pushed back-to-back with res_ready=1 -> results appear in order, one every 2 cycles, and s1/s2 match sel?b:a for all 16 with res_err=0.
- Fill/backpressure: res_ready=0, push 5 commands -> after the first is popped, 4 more fit (count=4, cmd_ready=0); the 6th is held off. Releasing res_ready drains all 5 in order; count returns to 0 and cmd_ready returns to 1.
- Fault detection: the bench forces lu_s1 to stuck-at-1 with cmd {a=0,b=0,sel1=0,sel2=0} -> res_s1=1, res_s2=0, res_err=1.
- SETTLE=3 build: single command -> lu_* stable for 3 cycles; res_valid rises exactly 4 edges after acceptance.
- Reset mid-operation: assert rst asynchronously while in DRIVE with count=2 -> immediately res_valid=0, count=0, lu_*=0, cmd_ready=1. After release, no stale result appears.
